// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, runs the request/ready handshake to
// instruction memory and hands fetched words to if_id, honouring jumps and holds from EX.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] jump_addr_i,
    input  logic        jump_en_i,
    input  logic        hold_flag_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        flush_o,
    output logic        hold_o
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_KILL  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_pc_r;
    logic [31:0] buf_inst_r;
    logic [31:0] buf_addr_r;
    logic [31:0] inst_r;
    logic [31:0] inst_addr_r;
    logic        req_r;
    logic        inst_valid_r;

    logic        xfer_s;
    logic [31:0] tgt_s;
    logic [31:0] pc_inc_s;
    logic        unused_jump_lsb_s;

    assign xfer_s            = req_r & imem_ready_i;
    assign tgt_s             = {jump_addr_i[31:2], 2'b00};
    assign pc_inc_s          = pc_r + 32'd4;
    assign unused_jump_lsb_s = ^jump_addr_i[1:0];

    // The request address is always the PC: KILL keeps the old PC until the
    // outstanding fetch retires, and HOLD has already advanced past the buffered word.
    assign imem_req_o   = req_r;
    assign imem_addr_o  = pc_r;
    assign inst_o       = inst_r;
    assign inst_addr_o  = inst_addr_r;
    assign inst_valid_o = inst_valid_r;
    assign flush_o      = jump_en_i;
    assign hold_o       = hold_flag_i;

    // Fetch state machine with registered request and delivery outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            pend_pc_r    <= 32'h0000_0000;
            buf_inst_r   <= 32'h0000_0000;
            buf_addr_r   <= 32'h0000_0000;
            inst_r       <= 32'h0000_0000;
            inst_addr_r  <= 32'h0000_0000;
            req_r        <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            inst_valid_r <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (jump_en_i) begin
                        req_r <= 1'b1;
                        // No request in flight (or it completes now): redirect immediately.
                        if (xfer_s || !req_r) begin
                            pc_r    <= tgt_s;
                            state_r <= ST_FETCH;
                        end else begin
                            pend_pc_r <= tgt_s;
                            state_r   <= ST_KILL;
                        end
                    end else if (hold_flag_i) begin
                        if (xfer_s) begin
                            buf_inst_r <= imem_rdata_i;
                            buf_addr_r <= pc_r;
                            pc_r       <= pc_inc_s;
                            req_r      <= 1'b0;
                            state_r    <= ST_HOLD;
                        end else begin
                            req_r   <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        req_r   <= 1'b1;
                        state_r <= ST_FETCH;
                        if (xfer_s) begin
                            inst_r       <= imem_rdata_i;
                            inst_addr_r  <= pc_r;
                            inst_valid_r <= 1'b1;
                            pc_r         <= pc_inc_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end
                end
                ST_KILL: begin
                    req_r <= 1'b1;
                    if (jump_en_i) begin
                        pend_pc_r <= tgt_s;
                    end else begin
                        pend_pc_r <= pend_pc_r;
                    end
                    // The latest jump wins even when it coincides with completion.
                    if (xfer_s) begin
                        pc_r    <= jump_en_i ? tgt_s : pend_pc_r;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_KILL;
                    end
                end
                ST_HOLD: begin
                    if (jump_en_i) begin
                        pc_r    <= tgt_s;
                        req_r   <= 1'b1;
                        state_r <= ST_FETCH;
                    end else if (!hold_flag_i) begin
                        inst_r       <= buf_inst_r;
                        inst_addr_r  <= buf_addr_r;
                        inst_valid_r <= 1'b1;
                        req_r        <= 1'b1;
                        state_r      <= ST_FETCH;
                    end else begin
                        req_r   <= 1'b0;
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    req_r   <= 1'b1;
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, a reset-during-kill sequence and
// a randomized run against a queue-based reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] jump_addr_i;
    logic        jump_en_i;
    logic        hold_flag_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        flush_o;
    logic        hold_o;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .jump_addr_i(jump_addr_i), .jump_en_i(jump_en_i),
        .hold_flag_i(hold_flag_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o), .flush_o(flush_o),
        .hold_o(hold_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic j, input logic [31:0] ja,
                         input logic h, input logic rd, input logic [31:0] rdt);
        rst = r; jump_en_i = j; jump_addr_i = ja; hold_flag_i = h;
        imem_ready_i = rd; imem_rdata_i = rdt;
    endtask

    typedef struct {
        logic        r, j, h, rd;
        logic [31:0] ja, rdt;
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_ia, e_inst;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic j, input logic [31:0] ja,
                                input logic h, input logic rd, input logic [31:0] rdt,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] eia, input logic [31:0] ei);
        vec_t v;
        v.r = r; v.j = j; v.ja = ja; v.h = h; v.rd = rd; v.rdt = rdt;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_ia = eia; v.e_inst = ei;
        return v;
    endfunction

    // Reference model state: next request address, outstanding flag, whether the
    // in-flight fetch is doomed, its redirect target, and the parked (held) word.
    typedef struct { logic [31:0] addr; logic [31:0] data; } word_t;
    logic [31:0] m_pc, m_redirect, m_ia, m_inst;
    logic        m_req, m_drop, m_valid;
    word_t       parked[$];

    task automatic model_reset();
        m_pc = 32'h0; m_redirect = 32'h0; m_ia = 32'h0; m_inst = 32'h0;
        m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
        parked.delete();
    endtask

    task automatic deliver(input logic [31:0] a, input logic [31:0] d);
        m_valid = 1'b1; m_ia = a; m_inst = d;
    endtask

    task automatic model_step();
        logic        xfer;
        logic [31:0] tgt;
        word_t       w;
        if (!rst) begin
            model_reset();
        end else begin
            xfer    = m_req && imem_ready_i;
            tgt     = jump_addr_i & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            if (parked.size() != 0) begin
                if (jump_en_i) begin
                    parked.delete(); m_pc = tgt; m_req = 1'b1;
                end else if (!hold_flag_i) begin
                    w = parked.pop_front(); deliver(w.addr, w.data); m_req = 1'b1;
                end
            end else if (m_drop) begin
                if (jump_en_i) m_redirect = tgt;
                if (xfer) begin m_pc = m_redirect; m_drop = 1'b0; end
            end else if (jump_en_i) begin
                if (xfer || !m_req) m_pc = tgt;
                else begin m_drop = 1'b1; m_redirect = tgt; end
                m_req = 1'b1;
            end else if (xfer) begin
                if (hold_flag_i) begin
                    w.addr = m_pc; w.data = imem_rdata_i; parked.push_back(w); m_req = 1'b0;
                end else begin
                    deliver(m_pc, imem_rdata_i);
                end
                m_pc = m_pc + 32'd4;
            end else begin
                m_req = 1'b1;
            end
        end
    endtask

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        logic r, j, h, rd;
        logic [31:0] ja, rdt;

        // r  j  jump_addr     h  rdy rdata          req addr          vld inst_addr     inst
        tbl[0]  = mk(0, 0, 32'h0,         0, 1, 32'hD000_0000, 0, 32'h0,         0, 32'h0,         32'h0);
        tbl[1]  = mk(1, 0, 32'h0,         0, 1, 32'hD000_0000, 1, 32'h0,         0, 32'h0,         32'h0);
        tbl[2]  = mk(1, 0, 32'h0,         0, 1, 32'hD000_0001, 1, 32'h4,         1, 32'h0,         32'hD000_0001);
        tbl[3]  = mk(1, 0, 32'h0,         0, 1, 32'hD000_0002, 1, 32'h8,         1, 32'h4,         32'hD000_0002);
        tbl[4]  = mk(1, 1, 32'h103,       0, 1, 32'hD000_0003, 1, 32'h100,       0, 32'h4,         32'hD000_0002);
        tbl[5]  = mk(1, 0, 32'h0,         0, 1, 32'hD000_0004, 1, 32'h104,       1, 32'h100,       32'hD000_0004);
        tbl[6]  = mk(1, 1, 32'h10,        0, 1, 32'hD000_0005, 1, 32'h10,        0, 32'h100,       32'hD000_0004);
        tbl[7]  = mk(1, 1, 32'h200,       0, 0, 32'hD000_0006, 1, 32'h10,        0, 32'h100,       32'hD000_0004);
        tbl[8]  = mk(1, 0, 32'h0,         0, 0, 32'hD000_0007, 1, 32'h10,        0, 32'h100,       32'hD000_0004);
        tbl[9]  = mk(1, 0, 32'h0,         0, 0, 32'hD000_0008, 1, 32'h10,        0, 32'h100,       32'hD000_0004);
        tbl[10] = mk(1, 0, 32'h0,         0, 1, 32'hD000_0009, 1, 32'h200,       0, 32'h100,       32'hD000_0004);
        tbl[11] = mk(1, 0, 32'h0,         0, 1, 32'hD000_000A, 1, 32'h204,       1, 32'h200,       32'hD000_000A);
        tbl[12] = mk(1, 1, 32'h20,        0, 1, 32'hD000_000B, 1, 32'h20,        0, 32'h200,       32'hD000_000A);
        tbl[13] = mk(1, 0, 32'h0,         1, 1, 32'hD000_000C, 0, 32'h24,        0, 32'h200,       32'hD000_000A);
        tbl[14] = mk(1, 0, 32'h0,         1, 1, 32'hD000_000D, 0, 32'h24,        0, 32'h200,       32'hD000_000A);
        tbl[15] = mk(1, 0, 32'h0,         1, 1, 32'hD000_000E, 0, 32'h24,        0, 32'h200,       32'hD000_000A);
        tbl[16] = mk(1, 0, 32'h0,         1, 1, 32'hD000_000F, 0, 32'h24,        0, 32'h200,       32'hD000_000A);
        tbl[17] = mk(1, 0, 32'h0,         0, 1, 32'hD000_0010, 1, 32'h24,        1, 32'h20,        32'hD000_000C);
        tbl[18] = mk(1, 0, 32'h0,         0, 1, 32'hD000_0011, 1, 32'h28,        1, 32'h24,        32'hD000_0011);
        tbl[19] = mk(1, 1, 32'hFFFF_FFFE, 0, 1, 32'hD000_0012, 1, 32'hFFFF_FFFC, 0, 32'h24,        32'hD000_0011);
        tbl[20] = mk(1, 0, 32'h0,         0, 1, 32'hD000_0013, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'hD000_0013);
        tbl[21] = mk(1, 0, 32'h0,         0, 1, 32'hD000_0014, 1, 32'h4,         1, 32'h0,         32'hD000_0014);
        tbl[22] = mk(1, 1, 32'h300,       0, 0, 32'hD000_0015, 1, 32'h4,         0, 32'h0,         32'hD000_0014);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].r, tbl[i].j, tbl[i].ja, tbl[i].h, tbl[i].rd, tbl[i].rdt);
            #1;
            chk("tbl_flush", {31'h0, flush_o}, {31'h0, tbl[i].j});
            chk("tbl_hold", {31'h0, hold_o}, {31'h0, tbl[i].h});
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_req", i), {31'h0, imem_req_o}, {31'h0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_inst_addr", i), inst_addr_o, tbl[i].e_ia);
            chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].e_inst);
        end

        // Reset while KILL holds a pending target: outputs clear at once, target never fetched.
        drive(0, 0, 32'h0, 0, 1, 32'hE000_0000);
        #1;
        chk("rst_kill_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_kill_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_kill_inst", inst_o, 32'h0);
        chk("rst_kill_inst_addr", inst_addr_o, 32'h0);
        @(posedge clk); #1;
        drive(1, 0, 32'h0, 0, 1, 32'hE000_0000);
        @(posedge clk); #1;
        chk("rel_req", {31'h0, imem_req_o}, 32'h1);
        chk("rel_addr0", imem_addr_o, 32'h0);
        chk("rel_valid0", {31'h0, inst_valid_o}, 32'h0);
        imem_rdata_i = 32'hE000_0001;
        @(posedge clk); #1;
        chk("rel_addr1", imem_addr_o, 32'h4);
        chk("rel_valid1", {31'h0, inst_valid_o}, 32'h1);
        chk("rel_inst_addr1", inst_addr_o, 32'h0);
        chk("rel_inst1", inst_o, 32'hE000_0001);
        @(posedge clk); #1;
        chk("rel_addr2", imem_addr_o, 32'h8);
        chk("rel_inst_addr2", inst_addr_o, 32'h4);

        // Randomized run against the reference model, starting from reset.
        model_reset();
        h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r   = (i == 0 || $urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 4) == 0) h = ~h;
            j   = ($urandom_range(0, 7) == 0);
            ja  = $urandom;
            rd  = ($urandom_range(0, 2) != 0);
            rdt = $urandom;
            drive(r, j, ja, h, rd, rdt);
            #1;
            chk("rnd_flush", {31'h0, flush_o}, {31'h0, j});
            chk("rnd_hold", {31'h0, hold_o}, {31'h0, h});
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_req", {31'h0, imem_req_o}, {31'h0, m_req});
            if (m_req) chk("rnd_addr", imem_addr_o, m_pc);
            chk("rnd_valid", {31'h0, inst_valid_o}, {31'h0, m_valid});
            chk("rnd_inst_addr", inst_addr_o, m_ia);
            chk("rnd_inst", inst_o, m_inst);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
